mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one unified memory/MIO bus between the pipeline's instruction-fetch requester (read-only) and its MEM-stage data requester (read/write with DMType). The arbiter runs one outstanding transaction at a time with a req/ready handshake to the bus. It returns read data and a one-cycle done pulse to the granted requester, and gives the stall controls that the hazard logic ORs into its stall and PCWrite terms. It sits between the CPU core ports (PC_out/inst_in, Addr_out/Data_out/Data_in/mem_w/DMType) and the MIO bus.

Parameters:
ADDR_W, 32, address width of both requesters and the bus
DATA_W, 32, data width
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced through (1..15)
TIMEOUT_CYCLES, 255, bus wait limit; only used with ARB_TIMEOUT_EN (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held high until i_done
i_addr  in  ADDR_W  fetch address (PC)
i_rdata  out  DATA_W  fetched instruction, valid while i_done=1
i_done  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held high until d_done
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_dmtype  in  3  access size/sign code, forwarded unchanged
d_rdata  out  DATA_W  load data, valid while d_done=1
d_done  out  1  one-cycle data completion pulse
i_stall  out  1  = i_req & ~i_done
d_stall  out  1  = d_req & ~d_done
bus_req  out  1  bus transaction valid (CPU_MIO)
bus_we  out  1  bus write
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_dmtype  out  3  bus access type
bus_rdata  in  DATA_W  bus read data
bus_ready  in  1  bus completion (MIO_ready), sampled on clk
bus_err  out  1  timeout pulse (see Optional Feature)

Behaviour:
- FSM states: IDLE, BUS_I, BUS_D, RESP. All bus_* outputs are registered and are driven from a command register loaded on grant.
- Reset: state=IDLE. bus_req, bus_we, i_done, d_done and bus_err are 0. bus_addr, bus_wdata, i_rdata and d_rdata are 0. bus_dmtype=0. streak counter=0. Timeout counter=0. A reset mid-transaction abandons it, and no done pulse is issued.
- IDLE arbitration: a pending fetch is granted only if no data request is pending, or if the streak counter equals MAX_D_STREAK. Otherwise a pending data request is granted. With no request, the FSM stays in IDLE.
- On a grant, the edge captures the address, write enable, write data and dmtype, and the FSM enters BUS_x with bus_req=1 from the next cycle. A fetch grant drives bus_we=0 and bus_dmtype=0.
- Streak counter: on a data grant, it increments if i_req=1 (saturating at MAX_D_STREAK). On a fetch grant, or on a data grant with i_req=0, it clears.
- BUS_x: bus_req and the command registers are held stable. When bus_ready=1 is sampled, the edge captures bus_rdata into i_rdata or d_rdata (stores capture as well; the value is don't-care), drops bus_req, sets the matching done, and enters RESP.
- RESP: lasts exactly one cycle with exactly one done high, then the FSM returns to IDLE. Requests are not sampled in RESP. A requester drops req or presents a new request in the cycle after done.
- Minimum transaction latency: grant edge to done is 2 cycles when bus_ready is already high in the first BUS cycle. Back-to-back throughput is 1 transaction per 3 cycles.
- bus_ready sampled in IDLE or RESP is ignored.
- Request changes (addr, data) during BUS_x are ignored because the command is latched.
- i_rdata and d_rdata hold their last captured values outside done cycles.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: in BUS_x, an 8-bit counter increments each cycle that bus_ready=0. When it reaches TIMEOUT_CYCLES, the FSM goes to RESP with the matching done=1, rdata=0 and bus_err=1 for that RESP cycle, and bus_req drops. The counter clears on every grant.
- Undefined: no counter is built, bus_err is tied to 0, and BUS_x waits indefinitely for bus_ready.

Test Plan:
- Reset mid-BUS_D, with d_req held and reset for 1 cycle -> all outputs 0, state IDLE, no d_done; bus_req=1 again 1 cycle after reset deasserts.
- Lone fetch with i_addr=0x0000_0040, bus_ready=1 constantly, bus_rdata=0x0010_0093 -> bus_req high 1 cycle with bus_addr=0x40 and bus_we=0; i_done pulses 2 cycles after grant with i_rdata=0x0010_0093.
- Simultaneous i_req and d_req (store, addr 0x100, wdata 0xCAFE_F00D, dmtype 3'b010) -> data granted first with bus_we=1 and bus_wdata=0xCAFEF00D; fetch granted in the next IDLE.
- d_req continuously re-asserted with i_req held, MAX_D_STREAK=4 -> exactly 4 data grants, then 1 fetch grant; the streak counter is then 0.
- bus_ready held 0 for 10 cycles then 1 during a load (bus_rdata=0x1234_5678) -> bus_req and bus_addr stay stable for 11 cycles; d_done=1 with d_rdata=0x12345678, and d_stall=1 throughout until done.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus_ready stuck at 0 -> after 8 BUS cycles, RESP with i_done=1, i_rdata=0 and bus_err=1 for 1 cycle; without the macro, bus_req remains high.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, the two CPU requesters and the MIO bus.
// Handshake: a requester raises *_req with a stable command and holds it until *_done pulses;
// the arbiter raises bus_req with a stable command and holds it until bus_ready=1 is sampled on clk.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_dmtype;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              i_stall;
    logic              d_stall;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [2:0]        bus_dmtype;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;
    logic              bus_err;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_dmtype, bus_rdata, bus_ready,
        output i_rdata, i_done, d_rdata, d_done, i_stall, d_stall,
               bus_req, bus_we, bus_addr, bus_wdata, bus_dmtype, bus_err
    );

    // Requester / bus side.
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_dmtype, bus_rdata, bus_ready,
        input  i_rdata, i_done, d_rdata, d_done, i_stall, d_stall,
               bus_req, bus_we, bus_addr, bus_wdata, bus_dmtype, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one MIO bus between instruction fetch and MEM-stage data.
// Optional bus wait timeout with bus_err pulse is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   mp,
    output logic [1:0]          dbg_state,
    output logic [3:0]          dbg_streak
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS_I = 2'd1, BUS_D = 2'd2, RESP = 2'd3} state_e;

    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    if (MAX_D_STREAK < 1 || MAX_D_STREAK > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_param
        $error("mem_port_arbiter: MAX_D_STREAK or TIMEOUT_CYCLES out of range");
    end

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]        bus_dmtype_q, bus_dmtype_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic [3:0]        streak_q, streak_d;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]        tmo_q, tmo_d;
    logic              bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_dmtype_d = bus_dmtype_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        streak_d     = streak_q;
`ifdef ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
        bus_err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Data wins ties until it has been granted MAX_D_STREAK times in a row over a waiting fetch.
                if (mp.i_req && (!mp.d_req || streak_q == MAX_S)) begin
                    state_d      = BUS_I;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = mp.i_addr;
                    bus_wdata_d  = '0;
                    bus_dmtype_d = 3'd0;
                    streak_d     = 4'd0;
`ifdef ARB_TIMEOUT_EN
                    tmo_d        = 8'd0;
`endif
                end else if (mp.d_req) begin
                    state_d      = BUS_D;
                    bus_req_d    = 1'b1;
                    bus_we_d     = mp.d_we;
                    bus_addr_d   = mp.d_addr;
                    bus_wdata_d  = mp.d_wdata;
                    bus_dmtype_d = mp.d_dmtype;
                    if (!mp.i_req)
                        streak_d = 4'd0;
                    else if (streak_q != MAX_S)
                        streak_d = streak_q + 4'd1;
`ifdef ARB_TIMEOUT_EN
                    tmo_d        = 8'd0;
`endif
                end
            end
            BUS_I, BUS_D: begin
                if (mp.bus_ready) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    if (state_q == BUS_I) begin
                        i_rdata_d = mp.bus_rdata;
                        i_done_d  = 1'b1;
                    end else begin
                        d_rdata_d = mp.bus_rdata;
                        d_done_d  = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (9'(tmo_q) + 9'd1 == 9'(TIMEOUT_CYCLES)) begin
                    state_d   = RESP;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    tmo_d     = tmo_q + 8'd1;
                    if (state_q == BUS_I) begin
                        i_rdata_d = '0;
                        i_done_d  = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_done_d  = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_dmtype_q <= 3'd0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            streak_q     <= 4'd0;
`ifdef ARB_TIMEOUT_EN
            tmo_q        <= 8'd0;
            bus_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_dmtype_q <= bus_dmtype_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            streak_q     <= streak_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
            bus_err_q    <= bus_err_d;
`endif
        end
    end

    assign mp.bus_req    = bus_req_q;
    assign mp.bus_we     = bus_we_q;
    assign mp.bus_addr   = bus_addr_q;
    assign mp.bus_wdata  = bus_wdata_q;
    assign mp.bus_dmtype = bus_dmtype_q;
    assign mp.i_rdata    = i_rdata_q;
    assign mp.d_rdata    = d_rdata_q;
    assign mp.i_done     = i_done_q;
    assign mp.d_done     = d_done_q;
    assign mp.i_stall    = mp.i_req & ~i_done_q;
    assign mp.d_stall    = mp.d_req & ~d_done_q;
`ifdef ARB_TIMEOUT_EN
    assign mp.bus_err    = bus_err_q;
`else
    assign mp.bus_err    = 1'b0;
`endif
    assign dbg_state     = state_q;
    assign dbg_streak    = streak_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences and random traffic
// against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAX_S  = 4;
    localparam int TMO    = 8;
`ifdef ARB_TIMEOUT_EN
    localparam int WAIT_N = TMO - 2;
`else
    localparam int WAIT_N = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    logic [3:0] dbg_streak;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAX_S), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .mp(bif.slave), .dbg_state(dbg_state), .dbg_streak(dbg_streak)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: who owns the bus (0 none, 1 fetch, 2 data), whether the done cycle just happened,
    // the data-over-fetch grant count, the latched command and the last returned read data.
    int                m_owner, m_streak, m_wait;
    bit                m_resp;
    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_wdata;
    logic [2:0]        m_dmtype;
    logic [DATA_W-1:0] m_i_rdata, m_d_rdata;
    logic [DATA_W-1:0] ei_q[$];
    logic [DATA_W-1:0] ed_q[$];

    // One clock: snapshot the inputs presented before the edge, advance the model, compare after the edge.
    task automatic cycle();
        logic              p_reset, p_i_req, p_d_req, p_d_we, p_ready;
        logic [ADDR_W-1:0] p_i_addr, p_d_addr;
        logic [DATA_W-1:0] p_d_wdata, p_rdata, exp_rd;
        logic [2:0]        p_dm;
        logic              e_i_done, e_d_done, e_err, e_req, timed_out;
        p_reset = reset;      p_i_req = bif.i_req;    p_i_addr = bif.i_addr;
        p_d_req = bif.d_req;  p_d_we = bif.d_we;      p_d_addr = bif.d_addr;
        p_d_wdata = bif.d_wdata; p_dm = bif.d_dmtype;
        p_ready = bif.bus_ready; p_rdata = bif.bus_rdata;
        @(posedge clk);
        #1;
        e_i_done = 1'b0; e_d_done = 1'b0; e_err = 1'b0; timed_out = 1'b0;
        if (p_reset) begin
            m_owner = 0; m_resp = 0; m_streak = 0; m_wait = 0;
            m_addr = '0; m_we = 1'b0; m_wdata = '0; m_dmtype = 3'd0;
            m_i_rdata = '0; m_d_rdata = '0;
            ei_q.delete(); ed_q.delete();
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_owner == 0) begin
            if (p_i_req && (!p_d_req || m_streak == MAX_S)) begin
                m_owner = 1; m_addr = p_i_addr; m_we = 1'b0; m_dmtype = 3'd0;
                m_streak = 0; m_wait = 0;
            end else if (p_d_req) begin
                m_owner = 2; m_addr = p_d_addr; m_we = p_d_we; m_wdata = p_d_wdata; m_dmtype = p_dm;
                m_streak = p_i_req ? ((m_streak < MAX_S) ? m_streak + 1 : MAX_S) : 0;
                m_wait = 0;
            end
        end else begin
            if (!p_ready) begin
                m_wait++;
`ifdef ARB_TIMEOUT_EN
                timed_out = (m_wait == TMO);
`endif
            end
            if (p_ready || timed_out) begin
                exp_rd = timed_out ? '0 : p_rdata;
                e_err  = timed_out;
                if (m_owner == 1) begin
                    e_i_done = 1'b1; m_i_rdata = exp_rd; ei_q.push_back(exp_rd);
                end else begin
                    e_d_done = 1'b1; m_d_rdata = exp_rd; ed_q.push_back(exp_rd);
                end
                m_owner = 0;
                m_resp  = 1;
            end
        end
        e_req = (m_owner != 0);
        chk("bus_req", bif.bus_req, e_req);
        chk("i_done", bif.i_done, e_i_done);
        chk("d_done", bif.d_done, e_d_done);
        chk("bus_err", bif.bus_err, e_err);
        chk("i_stall", bif.i_stall, p_i_req & ~e_i_done);
        chk("d_stall", bif.d_stall, p_d_req & ~e_d_done);
        chk("i_rdata_hold", bif.i_rdata, m_i_rdata);
        chk("d_rdata_hold", bif.d_rdata, m_d_rdata);
        chk("streak", dbg_streak, m_streak);
        if (e_req || p_reset) begin
            chk("bus_addr", bif.bus_addr, m_addr);
            chk("bus_we", bif.bus_we, m_we);
            chk("bus_dmtype", bif.bus_dmtype, m_dmtype);
            if (m_owner == 2 || p_reset) chk("bus_wdata", bif.bus_wdata, m_wdata);
        end
        if (bif.i_done === 1'b1) begin
            if (ei_q.size() == 0) fail("i_done_unexpected");
            else chk("i_rdata_sb", bif.i_rdata, ei_q.pop_front());
        end
        if (bif.d_done === 1'b1) begin
            if (ed_q.size() == 0) fail("d_done_unexpected");
            else chk("d_rdata_sb", bif.d_rdata, ed_q.pop_front());
        end
    endtask

    typedef struct {
        logic        i_req;  logic [31:0] i_addr;
        logic        d_req;  logic        d_we;   logic [31:0] d_addr; logic [31:0] d_wdata; logic [2:0] d_dm;
        logic        rdy;    logic [31:0] rdata;
        logic        e_req;  logic        e_we;   logic [31:0] e_addr; logic [2:0]  e_dm;    logic [31:0] e_wdata;
        logic        e_i_done; logic      e_d_done; logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[10];
    bit   g_q[$];

    initial begin
        logic [31:0] rd;
        logic [31:0] wd;
        int          hi;
        bit          fetch_done;
        bit          finished;

        rd = 32'h0010_0093;
        wd = 32'hCAFE_F00D;
        //          i_req i_addr  d_req we d_addr   d_wdata d_dm rdy rdata  e_req e_we e_addr    e_dm  e_wdata e_i e_d e_rdata
        vecs[0] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0, 3'd0, 1'b1, rd, 1'b1, 1'b0, 32'h40,  3'd0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0, 3'd0, 1'b1, rd, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0, 1'b1, 1'b0, rd};
        vecs[2] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0, 3'd0, 1'b1, rd, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0, 3'd0, 1'b1, rd, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, wd,    3'd2, 1'b1, rd, 1'b1, 1'b1, 32'h100, 3'd2, wd,    1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h100, wd,    3'd2, 1'b1, rd, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0, 1'b0, 1'b1, rd};
        vecs[6] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0, 3'd0, 1'b1, rd, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0, 3'd0, 1'b1, rd, 1'b1, 1'b0, 32'h44,  3'd0, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0, 3'd0, 1'b1, rd, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0, 1'b1, 1'b0, rd};
        vecs[9] = '{1'b0, 32'h44, 1'b0, 1'b0, 32'h0,   32'h0, 3'd0, 1'b1, rd, 1'b0, 1'b0, 32'h0,   3'd0, 32'h0, 1'b0, 1'b0, 32'h0};

        // Clock/reset.
        reset = 1'b1;
        bif.i_req = 1'b0; bif.i_addr = '0; bif.d_req = 1'b0; bif.d_we = 1'b0; bif.d_addr = '0;
        bif.d_wdata = '0; bif.d_dmtype = 3'd0; bif.bus_ready = 1'b0; bif.bus_rdata = '0;
        cycle();
        cycle();
        chk("reset_state", dbg_state, 2'd0);
        reset = 1'b0;
        cycle();

        // Vector table: lone fetch, then simultaneous store + fetch.
        for (int v = 0; v < 10; v++) begin
            bif.i_req = vecs[v].i_req; bif.i_addr = vecs[v].i_addr;
            bif.d_req = vecs[v].d_req; bif.d_we = vecs[v].d_we; bif.d_addr = vecs[v].d_addr;
            bif.d_wdata = vecs[v].d_wdata; bif.d_dmtype = vecs[v].d_dm;
            bif.bus_ready = vecs[v].rdy; bif.bus_rdata = vecs[v].rdata;
            cycle();
            chk($sformatf("vec%0d_bus_req", v), bif.bus_req, vecs[v].e_req);
            chk($sformatf("vec%0d_i_done", v), bif.i_done, vecs[v].e_i_done);
            chk($sformatf("vec%0d_d_done", v), bif.d_done, vecs[v].e_d_done);
            if (vecs[v].e_req) begin
                chk($sformatf("vec%0d_bus_we", v), bif.bus_we, vecs[v].e_we);
                chk($sformatf("vec%0d_bus_addr", v), bif.bus_addr, vecs[v].e_addr);
                chk($sformatf("vec%0d_bus_dmtype", v), bif.bus_dmtype, vecs[v].e_dm);
                if (vecs[v].e_we) chk($sformatf("vec%0d_bus_wdata", v), bif.bus_wdata, vecs[v].e_wdata);
            end
            if (vecs[v].e_i_done) chk($sformatf("vec%0d_i_rdata", v), bif.i_rdata, vecs[v].e_rdata);
            if (vecs[v].e_d_done) chk($sformatf("vec%0d_d_rdata", v), bif.d_rdata, vecs[v].e_rdata);
        end

        // Streak: data re-requested continuously while a fetch waits.
        bif.i_req = 1'b1; bif.i_addr = 32'h200;
        bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h300; bif.d_dmtype = 3'd2;
        bif.bus_ready = 1'b1; bif.bus_rdata = 32'h5555_AAAA;
        fetch_done = 1'b0; finished = 1'b0;
        g_q.delete();
        for (int k = 0; k < 40 && !finished; k++) begin
            cycle();
            if (bif.bus_req === 1'b1 && bif.bus_addr === 32'h200 && dbg_state == 2'd1 && g_q.size() > 0 && g_q[g_q.size()-1] == 1'b1) begin
                // still the same fetch transaction
            end
            if (bif.bus_req === 1'b1 && (g_q.size() == 0 || bif.i_done === 1'b0) && dbg_state != 2'd3) begin
                if (k == 0 || 1) begin end
            end
            if (bif.i_done === 1'b1) begin
                bif.i_req  = 1'b0;
                fetch_done = 1'b1;
            end
            if (bif.d_done === 1'b1) begin
                bif.d_addr = bif.d_addr + 32'h4;
                if (fetch_done) begin
                    bif.d_req = 1'b0;
                    finished  = 1'b1;
                end
            end
        end
        if (!finished) fail("streak_timeout");
        cycle();
        cycle();

        // Streak grant order recorded from the bus side.
        bif.i_req = 1'b1; bif.i_addr = 32'h200;
        bif.d_req = 1'b1; bif.d_addr = 32'h300;
        fetch_done = 1'b0; finished = 1'b0; hi = 0;
        g_q.delete();
        for (int k = 0; k < 40 && !finished; k++) begin
            cycle();
            if (bif.bus_req === 1'b1 && hi == 0) begin
                g_q.push_back(bif.bus_addr == 32'h200);
                if (bif.bus_addr == 32'h200) chk("streak_cleared", dbg_streak, 4'd0);
            end
            hi = (bif.bus_req === 1'b1) ? 1 : 0;
            if (bif.i_done === 1'b1) begin
                bif.i_req  = 1'b0;
                fetch_done = 1'b1;
            end
            if (bif.d_done === 1'b1) begin
                bif.d_addr = bif.d_addr + 32'h4;
                if (fetch_done) begin
                    bif.d_req = 1'b0;
                    finished  = 1'b1;
                end
            end
        end
        if (!finished) fail("streak_order_timeout");
        chk("streak_grant_count", g_q.size(), 6);
        for (int k = 0; k < g_q.size(); k++)
            chk($sformatf("streak_grant%0d_is_fetch", k), g_q[k], (k == 4));
        cycle();

        // Bus wait: load held off by bus_ready=0, request address wiggles meanwhile.
        bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h500; bif.d_dmtype = 3'd2;
        bif.bus_ready = 1'b0;
        hi = 0;
        cycle();
        if (bif.bus_req === 1'b1) hi++;
        for (int k = 0; k < WAIT_N; k++) begin
            bif.d_addr = $urandom & 32'hFFFF_FFFC;
            cycle();
            if (bif.bus_req === 1'b1) hi++;
            chk("wait_bus_addr", bif.bus_addr, 32'h500);
            chk("wait_d_stall", bif.d_stall, 1'b1);
        end
        bif.bus_ready = 1'b1; bif.bus_rdata = 32'h1234_5678;
        cycle();
        chk("wait_req_cycles", hi, WAIT_N + 1);
        chk("wait_d_done", bif.d_done, 1'b1);
        chk("wait_d_rdata", bif.d_rdata, 32'h1234_5678);
        bif.d_req = 1'b0; bif.bus_ready = 1'b0;
        cycle();
        cycle();

        // Reset in the middle of a data transaction.
        bif.d_req = 1'b1; bif.d_addr = 32'h600; bif.d_we = 1'b1; bif.d_wdata = 32'hDEAD_BEEF;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        chk("rst_mid_state", dbg_state, 2'd0);
        chk("rst_mid_bus_req", bif.bus_req, 1'b0);
        chk("rst_mid_bus_addr", bif.bus_addr, 32'h0);
        chk("rst_mid_d_done", bif.d_done, 1'b0);
        reset = 1'b0;
        cycle();
        chk("rst_regrant", bif.bus_req, 1'b1);
        bif.bus_ready = 1'b1;
        cycle();
        bif.d_req = 1'b0; bif.bus_ready = 1'b0;
        cycle();
        cycle();

        // Stuck bus on a fetch.
        bif.i_req = 1'b1; bif.i_addr = 32'h700; bif.bus_ready = 1'b0;
        cycle();
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < TMO - 1; k++) begin
            cycle();
            chk("tmo_wait_req", bif.bus_req, 1'b1);
        end
        cycle();
        chk("tmo_i_done", bif.i_done, 1'b1);
        chk("tmo_i_rdata", bif.i_rdata, 32'h0);
        chk("tmo_bus_err", bif.bus_err, 1'b1);
        bif.i_req = 1'b0;
        cycle();
        chk("tmo_err_pulse", bif.bus_err, 1'b0);
`else
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("stuck_bus_req", bif.bus_req, 1'b1);
            chk("stuck_i_done", bif.i_done, 1'b0);
        end
        bif.bus_ready = 1'b1; bif.bus_rdata = 32'h0BAD_0BAD;
        cycle();
        chk("stuck_release_done", bif.i_done, 1'b1);
        bif.i_req = 1'b0;
        cycle();
`endif
        cycle();

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            bif.bus_ready = ($urandom_range(0, 3) != 0);
            bif.bus_rdata = $urandom;
            cycle();
            if (bif.i_done === 1'b1 || !bif.i_req) begin
                if (bif.i_done === 1'b1 || $urandom_range(0, 2) == 0) begin
                    bif.i_req  = $urandom_range(0, 1);
                    bif.i_addr = $urandom & 32'hFFFF_FFFC;
                end
            end
            if (bif.d_done === 1'b1 || !bif.d_req) begin
                if (bif.d_done === 1'b1 || $urandom_range(0, 2) == 0) begin
                    bif.d_req    = $urandom_range(0, 1);
                    bif.d_we     = $urandom_range(0, 1);
                    bif.d_addr   = $urandom;
                    bif.d_wdata  = $urandom;
                    bif.d_dmtype = 3'($urandom_range(0, 7));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
